// File: rtl/muldiv_pkg.sv
// muldiv_pkg: shared encodings for the iterative multiply/divide unit.
// Operation codes and FSM states.
package muldiv_pkg;

  typedef enum logic [2:0] {
    OP_MULT  = 3'd0,
    OP_MULTU = 3'd1,
    OP_DIV   = 3'd2,
    OP_DIVU  = 3'd3,
    OP_MTHI  = 3'd4,
    OP_MTLO  = 3'd5
  } op_e;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_FIX  = 2'd2
  } state_e;

endpackage

// File: rtl/muldiv_unit_sign.sv
// muldiv_sign: magnitude/sign split of a WIDTH-bit value.
// flip forces negation so the same negator serves result fix-up.
module muldiv_sign #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] val,
  input  logic             is_signed,
  input  logic             flip,
  output logic [WIDTH-1:0] mag,
  output logic             neg
);

  assign neg = is_signed & val[WIDTH-1];
  assign mag = (neg | flip) ? -val : val;

endmodule

// File: rtl/muldiv_unit.sv
// muldiv_unit: iterative shift-add multiply / restoring divide
// with architectural HI/LO registers and start/busy/done handshake.
module muldiv_unit
  import muldiv_pkg::*;
#(
  parameter  int WIDTH = 32,
  localparam int CNT_W = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic             div_by_zero,
  output logic [WIDTH-1:0] hi_out,
  output logic [WIDTH-1:0] lo_out
);

  state_e               state_q, state_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic                 is_div_q, is_div_d;
  logic                 neg_q, neg_d;
  logic                 rneg_q, rneg_d;
  logic                 dz_q, dz_d;
  logic [WIDTH-1:0]     opa_q, opa_d;
  logic [WIDTH-1:0]     dvs_q, dvs_d;
  logic [2*WIDTH-1:0]   acc_q, acc_d;
  logic [WIDTH-1:0]     rem_q, rem_d;
  logic [WIDTH-1:0]     hi_q, hi_d;
  logic [WIDTH-1:0]     lo_q, lo_d;
  logic                 done_q, done_d;
  logic                 dbz_q, dbz_d;

  logic                 fix;
  logic                 sgn_op;
  logic                 is_mul, is_dv, is_mthi, is_mtlo;
  logic [WIDTH-1:0]     sa_val, sb_val;
  logic [WIDTH-1:0]     a_mag, b_mag;
  logic                 a_neg, b_neg;
  logic [WIDTH:0]       mul_sum;
  logic [WIDTH:0]       trial, diff;
  logic [2*WIDTH-1:0]   prod_fix;

  assign fix     = (state_q == S_FIX);
  assign sgn_op  = (op == OP_MULT) || (op == OP_DIV);
  assign is_mul  = (op == OP_MULT) || (op == OP_MULTU);
  assign is_dv   = (op == OP_DIV) || (op == OP_DIVU);
  assign is_mthi = (op == OP_MTHI);
  assign is_mtlo = (op == OP_MTLO);

  // operands in IDLE; quotient/remainder fix-up in FIX
  assign sa_val = fix ? acc_q[WIDTH-1:0] : a;
  assign sb_val = fix ? rem_q : b;

  muldiv_sign #(.WIDTH(WIDTH)) u_sa (
    .val       (sa_val),
    .is_signed (sgn_op & ~fix),
    .flip      (fix & neg_q),
    .mag       (a_mag),
    .neg       (a_neg)
  );

  muldiv_sign #(.WIDTH(WIDTH)) u_sb (
    .val       (sb_val),
    .is_signed (sgn_op & ~fix),
    .flip      (fix & rneg_q),
    .mag       (b_mag),
    .neg       (b_neg)
  );

  assign mul_sum  = {1'b0, acc_q[2*WIDTH-1:WIDTH]}
                  + (acc_q[0] ? {1'b0, dvs_q} : '0);
  assign trial    = {rem_q, acc_q[WIDTH-1]};
  assign diff     = trial - {1'b0, dvs_q};
  assign prod_fix = neg_q ? -acc_q : acc_q;

  // next-state, iteration step and HI/LO update
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    is_div_d = is_div_q;
    neg_d    = neg_q;
    rneg_d   = rneg_q;
    dz_d     = dz_q;
    opa_d    = opa_q;
    dvs_d    = dvs_q;
    acc_d    = acc_q;
    rem_d    = rem_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    done_d   = 1'b0;
    dbz_d    = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          unique case (1'b1)
            is_mul: begin
              state_d  = S_RUN;
              cnt_d    = CNT_W'(WIDTH);
              is_div_d = 1'b0;
              neg_d    = a_neg ^ b_neg;
              rneg_d   = 1'b0;
              dz_d     = 1'b0;
              opa_d    = a;
              dvs_d    = a_mag;
              acc_d    = {{WIDTH{1'b0}}, b_mag};
              rem_d    = '0;
            end
            is_dv: begin
              state_d  = S_RUN;
              cnt_d    = CNT_W'(WIDTH);
              is_div_d = 1'b1;
              neg_d    = a_neg ^ b_neg;
              rneg_d   = a_neg;
              dz_d     = (b == '0);
              opa_d    = a;
              dvs_d    = b_mag;
              acc_d    = {{WIDTH{1'b0}}, a_mag};
              rem_d    = '0;
            end
            is_mthi: hi_d = a;
            is_mtlo: lo_d = a;
            default: ;
          endcase
        end
      end
      S_RUN: begin
        cnt_d = cnt_q - CNT_W'(1);
        if (is_div_q) begin
          rem_d = diff[WIDTH] ? trial[WIDTH-1:0]
                              : diff[WIDTH-1:0];
          acc_d = {acc_q[2*WIDTH-1:WIDTH],
                   acc_q[WIDTH-2:0], ~diff[WIDTH]};
        end else begin
          acc_d = {mul_sum, acc_q[WIDTH-1:1]};
        end
        if (cnt_q == CNT_W'(1)) state_d = S_FIX;
      end
      S_FIX: begin
        state_d = S_IDLE;
        done_d  = 1'b1;
        if (dz_q) begin
          hi_d  = opa_q;
          lo_d  = '1;
          dbz_d = 1'b1;
        end else if (is_div_q) begin
          lo_d = a_mag;
          hi_d = b_mag;
        end else begin
          hi_d = prod_fix[2*WIDTH-1:WIDTH];
          lo_d = prod_fix[WIDTH-1:0];
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // state and datapath registers, cleared by async reset
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      is_div_q <= 1'b0;
      neg_q    <= 1'b0;
      rneg_q   <= 1'b0;
      dz_q     <= 1'b0;
      opa_q    <= '0;
      dvs_q    <= '0;
      acc_q    <= '0;
      rem_q    <= '0;
      hi_q     <= '0;
      lo_q     <= '0;
      done_q   <= 1'b0;
      dbz_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      is_div_q <= is_div_d;
      neg_q    <= neg_d;
      rneg_q   <= rneg_d;
      dz_q     <= dz_d;
      opa_q    <= opa_d;
      dvs_q    <= dvs_d;
      acc_q    <= acc_d;
      rem_q    <= rem_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
      done_q   <= done_d;
      dbz_q    <= dbz_d;
    end
  end

  assign busy        = (state_q != S_IDLE);
  assign done        = done_q;
  assign div_by_zero = dbz_q;
  assign hi_out      = hi_q;
  assign lo_out      = lo_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// tb_muldiv_unit: arithmetic reference model with per-cycle compare,
// plus directed vectors with hand-computed literal results.
module tb_muldiv_unit;

  logic        clk;
  logic        rst;
  logic        start;
  logic [2:0]  op;
  logic [31:0] a, b;
  logic        busy, done, div_by_zero;
  logic [31:0] hi_out, lo_out;

  int n_vec = 0;
  int n_err = 0;

  muldiv_unit #(.WIDTH(32)) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .op          (op),
    .a           (a),
    .b           (b),
    .busy        (busy),
    .done        (done),
    .div_by_zero (div_by_zero),
    .hi_out      (hi_out),
    .lo_out      (lo_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // reference model state
  logic        m_busy = 0, m_done = 0, m_dz = 0;
  logic [31:0] m_hi = 0, m_lo = 0;
  logic [31:0] p_hi = 0, p_lo = 0;
  logic        p_dz = 0;
  int          m_left = 0;

  function automatic void model_res(
    input  logic [2:0]  o,
    input  logic [31:0] x, y,
    output logic [31:0] h, l,
    output logic        z);
    longint          sp;
    longint unsigned up;
    int              sx, sy;
    z = 0; h = 0; l = 0;
    sx = $signed(x);
    sy = $signed(y);
    case (o)
      3'd0: begin
        sp = longint'(sx) * longint'(sy);
        h = sp[63:32]; l = sp[31:0];
      end
      3'd1: begin
        up = longint'({32'b0, x}) * longint'({32'b0, y});
        h = up[63:32]; l = up[31:0];
      end
      3'd2: begin
        if (y == 0) begin h = x; l = '1; z = 1; end
        else if (x == 32'h8000_0000 && y == 32'hFFFF_FFFF) begin
          l = x; h = 0;
        end else begin
          l = sx / sy; h = sx % sy;
        end
      end
      default: begin
        if (y == 0) begin h = x; l = '1; z = 1; end
        else begin l = x / y; h = x % y; end
      end
    endcase
  endfunction

  // transaction-level model: WIDTH+1 edges from accept to result
  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      m_busy = 0; m_done = 0; m_dz = 0;
      m_hi = 0; m_lo = 0; m_left = 0;
    end else begin
      m_done = 0; m_dz = 0;
      if (m_left > 0) begin
        m_left--;
        if (m_left == 0) begin
          m_busy = 0; m_done = 1; m_dz = p_dz;
          m_hi = p_hi; m_lo = p_lo;
        end
      end else if (start) begin
        if (op <= 3'd3) begin
          model_res(op, a, b, p_hi, p_lo, p_dz);
          m_left = 33; m_busy = 1;
        end else if (op == 3'd4) m_hi = a;
        else if (op == 3'd5) m_lo = a;
      end
    end
  end

  // per-cycle compare against the model
  always @(negedge clk) begin
    n_vec++;
    if ({busy, done, div_by_zero, hi_out, lo_out} !==
        {m_busy, m_done, m_dz, m_hi, m_lo}) begin
      n_err++;
      $display("FAIL cycle t=%0t got b=%b d=%b z=%b hi=%h lo=%h exp b=%b d=%b z=%b hi=%h lo=%h",
               $time, busy, done, div_by_zero, hi_out, lo_out,
               m_busy, m_done, m_dz, m_hi, m_lo);
    end
  end

  task automatic chk(input string name,
                     input logic [31:0] got, exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%h expected=%h", name, got, exp);
    end
  endtask

  // wait for done; optional MULTU 2*2 injection at cycle inj
  task automatic wait_done(input int inj, output int lat,
                           output int bcnt, output logic dzs);
    lat = -1; bcnt = 0; dzs = 0;
    for (int k = 0; k < 100; k++) begin
      @(negedge clk);
      start = 0;
      if (k == inj) begin
        start = 1; op = 3'd1; a = 2; b = 2;
      end
      if (busy) bcnt++;
      if (done) begin
        lat = k; dzs = div_by_zero;
        break;
      end
    end
  endtask

  task automatic run_op(input logic [2:0] o,
                        input logic [31:0] x, y,
                        output int lat, output int bcnt,
                        output logic dzs);
    @(negedge clk);
    start = 1; op = o; a = x; b = y;
    wait_done(-1, lat, bcnt, dzs);
  endtask

  int   lat, bcnt, dcnt;
  logic dzs;

  initial begin
    rst = 1; start = 0; op = 0; a = 0; b = 0;
    #3 rst = 0;
    repeat (2) @(negedge clk);
    chk("reset_hi", hi_out, 0);
    chk("reset_lo", lo_out, 0);
    chk("reset_busy", {31'b0, busy}, 0);
    #2 rst = 1;

    run_op(3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, lat, bcnt, dzs);
    chk("multu_lat", lat, 33);
    chk("multu_busy_cycles", bcnt, 33);
    chk("multu_hi", hi_out, 32'hFFFF_FFFE);
    chk("multu_lo", lo_out, 32'h0000_0001);

    run_op(3'd0, 32'hFFFF_FFFD, 32'd7, lat, bcnt, dzs);
    chk("mult_hi", hi_out, 32'hFFFF_FFFF);
    chk("mult_lo", lo_out, 32'hFFFF_FFEB);

    run_op(3'd2, 32'hFFFF_FFF9, 32'd2, lat, bcnt, dzs);
    chk("div_lo", lo_out, 32'hFFFF_FFFD);
    chk("div_hi", hi_out, 32'hFFFF_FFFF);

    run_op(3'd3, 32'd100, 32'd0, lat, bcnt, dzs);
    chk("dz_lat", lat, 33);
    chk("dz_flag", {31'b0, dzs}, 1);
    chk("dz_hi", hi_out, 32'd100);
    chk("dz_lo", lo_out, 32'hFFFF_FFFF);

    run_op(3'd2, 32'h8000_0000, 32'hFFFF_FFFF, lat, bcnt, dzs);
    chk("ovf_lo", lo_out, 32'h8000_0000);
    chk("ovf_hi", hi_out, 32'h0);
    chk("ovf_dz", {31'b0, dzs}, 0);

    @(negedge clk); start = 1; op = 3'd4; a = 32'h1234;
    @(negedge clk); op = 3'd5; a = 32'h5678;
    @(negedge clk); start = 0;
    repeat (3) @(negedge clk);
    chk("mthi", hi_out, 32'h1234);
    chk("mtlo", lo_out, 32'h5678);

    @(negedge clk); start = 1; op = 3'd6; a = 32'hDEAD;
    @(negedge clk); start = 0;
    repeat (2) @(negedge clk);
    chk("rsvd_hi", hi_out, 32'h1234);
    chk("rsvd_busy", {31'b0, busy}, 0);

    @(negedge clk); start = 1; op = 3'd3; a = 10; b = 3;
    wait_done(9, lat, bcnt, dzs);
    chk("divu_lat", lat, 33);
    chk("divu_lo", lo_out, 32'd3);
    chk("divu_hi", hi_out, 32'd1);
    start = 1; op = 3'd1; a = 2; b = 2;
    wait_done(-1, lat, bcnt, dzs);
    chk("b2b_lat", lat, 33);
    chk("b2b_lo", lo_out, 32'd4);
    chk("b2b_hi", hi_out, 32'd0);

    @(negedge clk); start = 1; op = 3'd1;
    a = 32'hFFFF; b = 32'hFFFF;
    repeat (15) begin @(negedge clk); start = 0; end
    chk("pre_rst_busy", {31'b0, busy}, 1);
    #2 rst = 0;
    #1;
    chk("rst_busy", {31'b0, busy}, 0);
    chk("rst_done", {31'b0, done}, 0);
    chk("rst_hi", hi_out, 0);
    chk("rst_lo", lo_out, 0);
    @(negedge clk); #2 rst = 1;
    dcnt = 0;
    repeat (40) begin
      @(negedge clk);
      if (done) dcnt++;
    end
    chk("no_done_after_rst", dcnt, 0);

    $display("== %0d vectors applied, %0d miscompares ==",
             n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/muldiv_unit.md
Name: muldiv_unit

Overview:
- Parametrised, iterative multiply/divide unit with architectural HI/LO registers.
- Successor to the combinational multiplier and fixed-load HI/LO register pair in the single-cycle datapath.
- Adds signed/unsigned multiply, signed/unsigned divide, and MTHI/MTLO writes.
- Provides a start/busy/done handshake so the datapath controller (multi-cycle or stalling) can wait on results.

Parameters:
- WIDTH, 32: operand width; HI and LO are each WIDTH bits.
- CNT_W, $clog2(WIDTH+1): width of the iteration counter (derived, not overridden).

Ports:
- clk  input  1  clock, rising edge.
- rst  input  1  reset, asynchronous, active-low; clears all state.
- start  input  1  request; sampled on a rising clk edge only while busy=0.
- op  input  3  operation, sampled with start: MULT=0, MULTU=1, DIV=2, DIVU=3, MTHI=4, MTLO=5; 6 and 7 are reserved.
- a  input  WIDTH  rs operand (multiplicand or dividend; value for MTHI/MTLO).
- b  input  WIDTH  rt operand (multiplier or divisor).
- busy  output  1  high while an iterative operation is in flight.
- done  output  1  one-cycle pulse; HI/LO hold the new result in that cycle.
- div_by_zero  output  1  one-cycle pulse coincident with done, for DIV/DIVU with b==0.
- hi_out  output  WIDTH  HI register.
- lo_out  output  WIDTH  LO register.

Behaviour:
- Reset (rst=0, asynchronous): state=IDLE; busy, done, div_by_zero, hi_out, lo_out all 0; counter and working registers 0.
- States: IDLE, RUN, FIX.
- IDLE + start + MULT/MULTU/DIV/DIVU at edge E0:
  - Latch operand magnitudes. Signed ops use absolute values; result sign is recorded.
  - Counter=WIDTH; go to RUN; busy=1 after E0.
- RUN, one iteration per edge, counter decrements.
  - Multiply: shift-add, one multiplier bit per cycle, into a 2*WIDTH product register.
  - Divide: restoring division, one quotient bit per cycle, with a (WIDTH+1)-bit partial remainder.
  - When counter reaches 1, next state is FIX.
- FIX (edge E_WIDTH+1):
  - Apply sign correction and write HI/LO.
  - Assert done=1 for exactly one cycle; busy falls on the same edge; return to IDLE.
  - Latency: done is high in the cycle after edge E_WIDTH+1, i.e. WIDTH+1 cycles after the start edge. WIDTH=32 gives 33.
- Multiply result: {HI,LO} = full 2*WIDTH product. Signed product is negated when the operand signs differ.
- Divide result: LO=quotient, HI=remainder.
  - Signed quotient truncates toward zero.
  - Remainder takes the sign of the dividend.
- DIV of -2^(WIDTH-1) by -1: LO=-2^(WIDTH-1) (wraps), HI=0. No flag.
- Divide by zero (b==0, DIV or DIVU):
  - The full WIDTH+1 cycle latency is kept.
  - HI=a, LO=all ones; div_by_zero pulses with done.
- MTHI / MTLO in IDLE: HI or LO is written with a at E0. No busy, no done; the other register is unchanged. The value is visible on the outputs after E0.
- Reserved op with start: ignored; no state change.
- start while busy=1: ignored, with no queueing; the requester must hold or retry.
- start in the same cycle done=1: accepted, since state is already IDLE. The next op begins and the previous HI/LO result stays visible until the new FIX.
- HI/LO change only at FIX, MTHI/MTLO, or reset. They are stable throughout RUN.
- Reset asserted mid-RUN: operation abandoned; all outputs and HI/LO immediately 0.

Decomposition:
- Package muldiv_pkg contains:
  - op encodings: OP_MULT, OP_MULTU, OP_DIV, OP_DIVU, OP_MTHI, OP_MTLO;
  - state encoding: S_IDLE, S_RUN, S_FIX.
- Sub-module muldiv_sign (combinational): takes a WIDTH-bit value and a signed flag, and returns the magnitude plus sign bit. It is used for both operands; its negate path is reused in FIX.
- FSM, counter and datapath registers remain in muldiv_unit.

Test Plan:
- Reset, then MULTU a=0xFFFFFFFF, b=0xFFFFFFFF -> done at cycle 33; HI=0xFFFFFFFE, LO=0x00000001; busy high for cycles 1..33 only.
- MULT a=-3 (0xFFFFFFFD), b=7 -> HI=0xFFFFFFFF, LO=0xFFFFFFEB. Then DIV a=-7, b=2 -> LO=0xFFFFFFFD (-3), HI=0xFFFFFFFF (-1).
- DIVU a=100, b=0 -> done at cycle 33 with div_by_zero=1, HI=100, LO=0xFFFFFFFF. DIV a=0x80000000, b=-1 -> LO=0x80000000, HI=0, div_by_zero=0.
- MTHI a=0x1234 then MTLO a=0x5678 on consecutive cycles -> hi_out=0x1234, lo_out=0x5678; busy and done never asserted.
- DIVU 10/3 running; at cycle 10 pulse start with MULTU 2*2 -> ignored; result LO=3, HI=1. Then start on the done cycle -> accepted; LO=4, HI=0 after 33 more cycles.
- MULTU started; rst=0 at cycle 15 -> busy, done, hi_out, lo_out go to 0 asynchronously. After release, no done pulse appears.
